// File: rtl/sim_run_ctrl.sv
// Run controller for core simulation: sequences core reset, runs the core and
// ends the run on a halt-address store, a PC stall or a cycle timeout.
module sim_run_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 3,
  parameter int unsigned MAX_CYCLES  = 250,
  parameter int unsigned STALL_LIMIT = 16,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 32'h0000_FFFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SC_W = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] STAT_PASS  = 2'b00;
  localparam logic [1:0] STAT_ERR   = 2'b01;
  localparam logic [1:0] STAT_STALL = 2'b10;
  localparam logic [1:0] STAT_TMO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [RC_W-1:0]   rc_r, rc_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_sat_s;
  logic [1:0]        status_r, status_nxt_s;
  logic [DATA_W-1:0] result_r, result_nxt_s;
  logic [ADDR_W-1:0] prev_pc_r, prev_pc_nxt_s;
  logic [SC_W-1:0]   stall_r, stall_nxt_s;
  logic              core_rst_r, running_r, done_r;
  logic              halt_s, pc_same_s, stall_hit_s, timeout_s;

  // Run-cycle event decode; cnt_r==0 marks the first RUN cycle, which has no prior PC
  always_comb begin
    cnt_sat_s   = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
    halt_s      = mem_we && (mem_addr == HALT_ADDR);
    pc_same_s   = (cnt_r != {CNT_W{1'b0}}) && (pc == prev_pc_r);
    stall_hit_s = pc_same_s && (stall_r == SC_W'(STALL_LIMIT - 1));
    timeout_s   = (cnt_r == CNT_W'(MAX_CYCLES - 1));
  end

  // Next-state and run bookkeeping
  always_comb begin
    state_nxt_s   = state_r;
    rc_nxt_s      = rc_r;
    cnt_nxt_s     = cnt_r;
    status_nxt_s  = status_r;
    result_nxt_s  = result_r;
    prev_pc_nxt_s = prev_pc_r;
    stall_nxt_s   = stall_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s  = ST_RESET;
          rc_nxt_s     = RC_W'(RST_CYCLES - 1);
          cnt_nxt_s    = {CNT_W{1'b0}};
          status_nxt_s = STAT_PASS;
          result_nxt_s = {DATA_W{1'b0}};
          stall_nxt_s  = {SC_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RESET: begin
        if (rc_r == {RC_W{1'b0}}) begin
          state_nxt_s = ST_RUN;
        end else begin
          rc_nxt_s = rc_r - RC_W'(1);
        end
      end
      ST_RUN: begin
        cnt_nxt_s     = cnt_sat_s;
        prev_pc_nxt_s = pc;
        if (pc_same_s) begin
          stall_nxt_s = stall_r + SC_W'(1);
        end else begin
          stall_nxt_s = {SC_W{1'b0}};
        end
        // Priority: halt store, then stall, then timeout
        if (halt_s) begin
          state_nxt_s  = ST_DONE;
          result_nxt_s = mem_wdata;
          if (mem_wdata == DATA_W'(1)) begin
            status_nxt_s = STAT_PASS;
          end else begin
            status_nxt_s = STAT_ERR;
          end
        end else if (stall_hit_s) begin
          state_nxt_s  = ST_DONE;
          status_nxt_s = STAT_STALL;
        end else if (timeout_s) begin
          state_nxt_s  = ST_DONE;
          status_nxt_s = STAT_TMO;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rc_r       <= {RC_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      status_r   <= STAT_PASS;
      result_r   <= {DATA_W{1'b0}};
      prev_pc_r  <= {ADDR_W{1'b0}};
      stall_r    <= {SC_W{1'b0}};
      core_rst_r <= 1'b1;
      running_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rc_r       <= rc_nxt_s;
      cnt_r      <= cnt_nxt_s;
      status_r   <= status_nxt_s;
      result_r   <= result_nxt_s;
      prev_pc_r  <= prev_pc_nxt_s;
      stall_r    <= stall_nxt_s;
      core_rst_r <= (state_nxt_s != ST_RUN);
      running_r  <= (state_nxt_s == ST_RUN);
      done_r     <= (state_nxt_s == ST_DONE);
    end
  end

  assign core_rst    = core_rst_r;
  assign running     = running_r;
  assign done        = done_r;
  assign status      = status_r;
  assign cycle_count = cnt_r;
  assign result      = result_r;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: each run pushes its expected outcome,
// a monitor pops and compares when done rises.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        core_rst, running, done;
  logic [1:0]  status;
  logic [31:0] cycle_count, result;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic done_seen = 1'b0;

  sim_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
    .running(running), .done(done), .status(status),
    .cycle_count(cycle_count), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] st, input logic [31:0] cnt, input logic [31:0] res);
    exp_t e;
    e.st = st; e.cnt = cnt; e.res = res;
    exp_q.push_back(e);
  endtask

  // Monitor: on each rising done, pop the expected outcome and compare
  always @(negedge clk) begin
    if (done && !done_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("status", 64'(status), 64'(e.st));
        check("cycle_count", 64'(cycle_count), 64'(e.cnt));
        check("result", 64'(result), 64'(e.res));
        check("done_core_rst", 64'(core_rst), 64'd1);
        check("done_running", 64'(running), 64'd0);
      end
    end
    done_seen = done;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_running"}, 64'(running), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_status"}, 64'(status), 64'd0);
    check({tag, "_count"}, 64'(cycle_count), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
  endtask

  // One run: start pulse, 3 reset cycles, then n RUN cycles of stimulus
  task automatic run(input int n, input int halt_cyc, input logic [31:0] halt_data,
                     input int side_cyc, input int stall_from, input bit wait_end);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_reset_vals("enter_reset");
    tick();
    check("rst_cyc2", 64'(core_rst), 64'd1);
    tick();
    check("rst_cyc3", 64'(core_rst), 64'd1);
    tick();
    check("run_core_rst", 64'(core_rst), 64'd0);
    check("run_running", 64'(running), 64'd1);
    check("run_count0", 64'(cycle_count), 64'd0);
    for (int k = 1; k <= n; k++) begin
      pc        = (stall_from != 0 && k >= stall_from) ? 32'h40 : 32'h100 + 32'(k * 4);
      mem_we    = (k == halt_cyc) || (k == side_cyc);
      mem_addr  = (k == halt_cyc) ? 32'h0000_FFFC : 32'h0000_FFF8;
      mem_wdata = (k == halt_cyc) ? halt_data : 32'h1;
      tick();
      if (k == 1) check("first_count", 64'(cycle_count), 64'd1);
    end
    mem_we = 1'b0;
    if (wait_end) begin
      for (int i = 0; i < 8 && !done; i++) tick();
      check("done_within_bound", 64'(done), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("por");
    rst = 1'b0;
    tick();
    check("idle_core_rst", 64'(core_rst), 64'd1);

    push(2'b00, 32'd10, 32'd1);
    run(10, 10, 32'd1, 0, 0, 1'b1);
    push(2'b01, 32'd10, 32'hDEAD);
    run(10, 10, 32'hDEAD, 5, 0, 1'b1);
    push(2'b10, 32'd17, 32'd0);
    run(17, 0, 32'd0, 0, 1, 1'b1);
    push(2'b00, 32'd17, 32'd1);
    run(17, 17, 32'd1, 0, 1, 1'b1);
    push(2'b11, 32'd250, 32'd0);
    run(250, 0, 32'd0, 0, 0, 1'b1);
    push(2'b00, 32'd250, 32'd1);
    run(250, 250, 32'd1, 0, 0, 1'b1);

    // Reset during RUN cycle 7
    run(6, 0, 32'd0, 0, 0, 1'b0);
    pc  = 32'h200;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("mid_run_rst");
    tick();
    check("post_rst_idle_done", 64'(done), 64'd0);

    // Identical runs from IDLE and then restarted from DONE
    push(2'b00, 32'd10, 32'd1);
    run(10, 10, 32'd1, 0, 0, 1'b1);
    push(2'b00, 32'd10, 32'd1);
    run(10, 10, 32'd1, 0, 0, 1'b1);

    tick();
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Run controller for simulating the processor cores: it sequences core reset, runs the core, and decides when and how the run ends.
- It drives the core's reset, counts run cycles, and watches the core's PC and data-memory store bus.
- A run ends on a halt-address store, a PC stall, or a cycle timeout. The outcome is reported as status plus cycle count.
- It is the parametrised successor to a fixed reset-pulse-and-fixed-runtime harness. It sits between the clock/reset source and a core top.

Parameters:
- ADDR_W, 32, width of pc and mem_addr
- DATA_W, 32, width of mem_wdata and result
- CNT_W, 32, width of cycle_count
- RST_CYCLES, 3, cycles core_rst is held during the RESET state (>=1)
- MAX_CYCLES, 250, RUN cycles before a timeout (>=2, must fit in CNT_W)
- STALL_LIMIT, 16, consecutive unchanged-PC comparisons that end the run (>=1)
- HALT_ADDR, 32'h0000_FFFC, store address that ends the run

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- pc  in  ADDR_W  core program counter
- mem_we  in  1  core data-memory write enable
- mem_addr  in  ADDR_W  core data-memory address
- mem_wdata  in  DATA_W  core data-memory write data
- core_rst  out  1  reset to the core, active-high
- running  out  1  high in RUN
- done  out  1  high in DONE
- status  out  2  run outcome, valid when done: 00 pass, 01 fail, 10 stall, 11 timeout
- cycle_count  out  CNT_W  RUN cycles elapsed, including the terminating cycle
- result  out  DATA_W  mem_wdata captured by the halt store; 0 otherwise

Behaviour:
Reset:
- Reset is synchronous: clk and rst are the only clock and reset, and rst is active-high, sampled on the rising edge.
- rst=1 puts the block in IDLE with core_rst=1, running=0, done=0, status=00, cycle_count=0, result=0.
- rst overrides everything, including mid-RUN; all outputs take reset values at that edge.

States (IDLE, RESET, RUN, DONE):
- IDLE: core_rst=1. start=1 moves to RESET.
- RESET: core_rst=1 for exactly RST_CYCLES cycles (down-counter), then RUN.
  - Entering RESET clears done, status, cycle_count and result.
  - start is ignored.
- RUN: core_rst=0, running=1.
  - cycle_count increments every RUN cycle; the first RUN cycle makes it 1.
  - start is ignored.
  - pc and the memory bus are ignored outside RUN.
- DONE: core_rst=1 (core frozen), running=0, done=1.
  - status, result and cycle_count are held.
  - start=1 moves to RESET (restart).

Termination (all evaluated in a RUN cycle; done rises at the next edge):
- Halt store: mem_we=1 and mem_addr==HALT_ADDR. result<=mem_wdata. status=00 if mem_wdata==1, else 01.
- Stall:
  - A prev_pc register is loaded every RUN cycle.
  - No comparison is made on the first RUN cycle.
  - stall_cnt increments when pc==prev_pc and clears when they differ.
  - When the increment would reach STALL_LIMIT, the run ends with status=10.
- Timeout: when cycle_count==MAX_CYCLES-1 at the start of a RUN cycle, it becomes MAX_CYCLES and status=11.
- Priority when several occur in the same cycle: halt store > stall > timeout.
- cycle_count saturates; it never wraps.

Test Plan:
1. rst for 2 cycles, then a 1-cycle start pulse (RST_CYCLES=3) -> core_rst stays high exactly 3 cycles after leaving IDLE, then falls; running rises with it; cycle_count reads 1 after the first RUN edge.
2. Changing pc each cycle; store of 1 to 0xFFFC in RUN cycle 10 -> next cycle done=1, status=00, result=1, cycle_count=10, core_rst=1.
3. Same as 2 but store data 0xDEAD; also a store to 0xFFF8 at cycle 5 -> the 0xFFF8 store is ignored; done at cycle 10, status=01, result=0xDEAD.
4. pc held at 0x40 from RUN cycle 1 (STALL_LIMIT=16) -> status=10, cycle_count=17.
5. pc always changing, no halt store (MAX_CYCLES=250) -> status=11, cycle_count=250. Variant: halt store exactly in cycle 250 -> status=00, cycle_count=250.
6. rst asserted in RUN cycle 7 -> IDLE with all outputs at reset values. Then from DONE, start -> RESET re-entered; done, status, result and cycle_count cleared; the second run behaves identically to the first.
